ysyx_25040118_regfile_sb: RTL and testbench

//   Parametrised GPR file with NREAD combinational read ports, one write port,

---
 rtl/ysyx_25040118_regfile_sb.sv | 103 ++++++++++
 tb/tb_ysyx_25040118_regfile_sb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040118_regfile_sb.sv
// GPR file with NREAD combinational read ports, one write port, optional
// write-to-read forwarding and a per-register busy scoreboard with busy count.
module ysyx_25040118_regfile_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
  output logic [NREAD*DATA_WIDTH-1:0]   rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic                          set_en,
  input  logic [ADDR_WIDTH-1:0]         set_addr,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

  logic set_hit, clr_hit, cnt_inc, cnt_dec;
  logic wr_hit;

  assign wr_hit = wen && (waddr != '0);

  always_comb begin
    rf_d = rf_q;
    if (wr_hit) begin
      rf_d[waddr] = wdata;
    end
    rf_d[0] = '0;
  end

  // A set on the same index as a clear wins: the newly issued producer owns it.
  always_comb begin
    set_hit = set_en && (set_addr != '0);
    clr_hit = wr_hit && !(set_hit && (set_addr == waddr));
    busy_d  = busy_q;
    if (clr_hit) begin
      busy_d[waddr] = 1'b0;
    end
    if (set_hit) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Incremental popcount: at most one bit rises and one falls per edge.
  always_comb begin
    cnt_inc    = set_hit && !busy_q[set_addr];
    cnt_dec    = clr_hit && busy_q[waddr];
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_d = busy_cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_d = busy_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q       <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic                  fwd;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    fwd   = 1'b0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra  = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      fwd = (BYPASS != 0) && wen && (waddr == ra);
      if (ra == '0) begin
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy[k]                          = 1'b0;
      end else begin
        rdata[k*DATA_WIDTH +: DATA_WIDTH] = fwd ? wdata : rf_q[ra];
        rbusy[k]                          = busy_q[ra] && !fwd;
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_ysyx_25040118_regfile_sb.sv
// Scoreboard bench: two instances (forwarding on/off) share one stimulus stream;
// expectations are queued at drive time and checked mid-cycle by a monitor.
module tb_ysyx_25040118_regfile_sb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;
  localparam int unsigned DA = 0;
  localparam int unsigned DB = 1;
  localparam int unsigned K_RD  = 0;
  localparam int unsigned K_BZ  = 1;
  localparam int unsigned K_CNT = 2;

  logic             clk;
  logic             rst_n;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR*AW-1:0] raddr;
  logic             set_en;
  logic [AW-1:0]    set_addr;
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic [NR-1:0]    rbusy_a, rbusy_b;
  logic [AW:0]      cnt_a, cnt_b;

  ysyx_25040118_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .set_en(set_en), .set_addr(set_addr), .busy_cnt(cnt_a)
  );

  ysyx_25040118_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .set_en(set_en), .set_addr(set_addr), .busy_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned dut;
    int unsigned kind;
    int unsigned port;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, updated from the same inputs the DUTs see.
  bit [31:0] m_rf [32];
  bit [31:0] m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rf   <= '{default: '0};
      m_busy <= '0;
    end else begin
      if (wen && waddr != 0) begin
        m_rf[waddr]   <= wdata;
        m_busy[waddr] <= 1'b0;
      end
      if (set_en && set_addr != 0) m_busy[set_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wen && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_bz(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wen && waddr == a) return '0;
    return {31'b0, m_busy[a]};
  endfunction

  function automatic logic [31:0] m_cnt();
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] actual(input int unsigned d, input int unsigned k, input int unsigned p);
    logic [31:0] v;
    if (k == K_RD)      v = (d == DA) ? rdata_a[p*DW +: DW] : rdata_b[p*DW +: DW];
    else if (k == K_BZ) v = {31'b0, (d == DA) ? rbusy_a[p] : rbusy_b[p]};
    else                v = {26'b0, (d == DA) ? cnt_a : cnt_b};
    return v;
  endfunction

  task automatic chk(input string nm, input int unsigned d, input int unsigned k,
                     input int unsigned p, input logic [31:0] v);
    chk_t e;
    e.name = nm; e.dut = d; e.kind = k; e.port = p; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wen = w; waddr = wa; wdata = wd; set_en = s; set_addr = sa;
    raddr = {r2, r1, r0};
  endtask

  // Monitor: samples 3 time units after the falling edge, well before the next rising edge.
  initial begin
    chk_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #3;
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual(e.dut, e.kind, e.port);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s dut=%0d kind=%0d port=%0d got=%h exp=%h",
                   e.name, e.dut, e.kind, e.port, act, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] ra [NR];
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 5, 5, 5);
    tick();
    chk("rst_rd", DA, K_RD, 0, 32'h0);
    chk("rst_cnt_a", DA, K_CNT, 0, 32'h0);
    chk("rst_cnt_b", DB, K_CNT, 0, 32'h0);
    chk("rst_bz", DA, K_BZ, 0, 32'h0);
    tick();
    rst_n = 1'b1;

    // Reset mid-operation
    tick(); drive(1, 5, 32'hDEAD, 1, 6, 5, 6, 5);
    chk("t1_byp", DA, K_RD, 0, 32'hDEAD);
    chk("t1_nobyp", DB, K_RD, 0, 32'h0);
    chk("t1_cnt0", DA, K_CNT, 0, 32'h0);
    tick(); drive(0, 0, 0, 0, 0, 5, 6, 5);
    chk("t1_wr_a", DA, K_RD, 0, 32'hDEAD);
    chk("t1_wr_b", DB, K_RD, 0, 32'hDEAD);
    chk("t1_bz6", DA, K_BZ, 1, 32'h1);
    chk("t1_cnt1", DA, K_CNT, 0, 32'h1);
    tick(); rst_n = 1'b0;
    chk("t1_rst_rd_a", DA, K_RD, 0, 32'h0);
    chk("t1_rst_rd_b", DB, K_RD, 2, 32'h0);
    chk("t1_rst_bz", DA, K_BZ, 1, 32'h0);
    chk("t1_rst_cnt_a", DA, K_CNT, 0, 32'h0);
    chk("t1_rst_cnt_b", DB, K_CNT, 0, 32'h0);
    #4 rst_n = 1'b1;
    tick();
    chk("t1_post_rd", DA, K_RD, 0, 32'h0);
    chk("t1_post_cnt", DA, K_CNT, 0, 32'h0);

    // Register 0
    tick(); drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    chk("t2_rd0_p0", DA, K_RD, 0, 32'h0);
    chk("t2_rd0_p1", DA, K_RD, 1, 32'h0);
    chk("t2_rd0_p2", DA, K_RD, 2, 32'h0);
    chk("t2_rd0_b", DB, K_RD, 0, 32'h0);
    chk("t2_bz0", DA, K_BZ, 0, 32'h0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rd0_next", DA, K_RD, 0, 32'h0);
    chk("t2_bz0_next", DA, K_BZ, 0, 32'h0);
    chk("t2_cnt", DA, K_CNT, 0, 32'h0);

    // Forwarding
    tick(); drive(1, 7, 32'h1234, 0, 0, 7, 7, 0);
    chk("t3_byp_p0", DA, K_RD, 0, 32'h1234);
    chk("t3_byp_p1", DA, K_RD, 1, 32'h1234);
    chk("t3_old_p0", DB, K_RD, 0, 32'h0);
    chk("t3_old_p1", DB, K_RD, 1, 32'h0);
    tick(); drive(0, 0, 0, 0, 0, 7, 7, 0);
    chk("t3_new_p0", DB, K_RD, 0, 32'h1234);
    chk("t3_new_p1", DB, K_RD, 1, 32'h1234);
    chk("t3_keep", DA, K_RD, 0, 32'h1234);

    // Scoreboard set then clear
    tick(); drive(0, 0, 0, 1, 3, 3, 3, 3);
    chk("t4_bz_pre", DA, K_BZ, 0, 32'h0);
    chk("t4_cnt_pre", DA, K_CNT, 0, 32'h0);
    tick(); drive(0, 0, 0, 0, 0, 3, 3, 3);
    chk("t4_bz_a", DA, K_BZ, 0, 32'h1);
    chk("t4_bz_b", DB, K_BZ, 0, 32'h1);
    chk("t4_cnt_a", DA, K_CNT, 0, 32'h1);
    chk("t4_cnt_b", DB, K_CNT, 0, 32'h1);
    tick(); drive(1, 3, 32'h33, 0, 0, 3, 3, 3);
    chk("t4_bz_fwd_p0", DA, K_BZ, 0, 32'h0);
    chk("t4_bz_fwd_p2", DA, K_BZ, 2, 32'h0);
    chk("t4_bz_nofwd", DB, K_BZ, 0, 32'h1);
    chk("t4_cnt_hold", DA, K_CNT, 0, 32'h1);
    tick(); drive(0, 0, 0, 0, 0, 3, 3, 3);
    chk("t4_bz_clr_a", DA, K_BZ, 0, 32'h0);
    chk("t4_bz_clr_b", DB, K_BZ, 0, 32'h0);
    chk("t4_cnt_clr_a", DA, K_CNT, 0, 32'h0);
    chk("t4_cnt_clr_b", DB, K_CNT, 0, 32'h0);
    chk("t4_rd", DA, K_RD, 1, 32'h33);

    // Set priority, re-set, clear of non-busy
    tick(); drive(0, 0, 0, 1, 9, 9, 11, 9);
    chk("t5_cnt0", DA, K_CNT, 0, 32'h0);
    tick(); drive(1, 9, 32'h99, 1, 9, 9, 11, 9);
    chk("t5_sc_bz_a", DA, K_BZ, 0, 32'h0);
    chk("t5_sc_bz_b", DB, K_BZ, 0, 32'h1);
    chk("t5_sc_cnt", DA, K_CNT, 0, 32'h1);
    tick(); drive(0, 0, 0, 1, 9, 9, 11, 9);
    chk("t5_stay_bz", DA, K_BZ, 0, 32'h1);
    chk("t5_stay_cnt", DA, K_CNT, 0, 32'h1);
    chk("t5_rd99", DA, K_RD, 0, 32'h99);
    tick(); drive(1, 9, 32'h999, 1, 11, 9, 11, 9);
    chk("t5_reset_cnt", DA, K_CNT, 0, 32'h1);
    chk("t5_bz9_fwd", DA, K_BZ, 0, 32'h0);
    chk("t5_bz11_pre", DA, K_BZ, 1, 32'h0);
    tick(); drive(1, 9, 32'hAAA, 0, 0, 9, 11, 9);
    chk("t5_swap_cnt", DA, K_CNT, 0, 32'h1);
    chk("t5_bz11", DA, K_BZ, 1, 32'h1);
    chk("t5_bz9_b", DB, K_BZ, 0, 32'h0);
    chk("t5_rd_fwd", DA, K_RD, 0, 32'hAAA);
    chk("t5_rd_old", DB, K_RD, 0, 32'h999);
    tick(); drive(1, 11, 32'hB, 0, 0, 9, 11, 9);
    chk("t5_nb_clr_cnt", DA, K_CNT, 0, 32'h1);
    chk("t5_bz11_fwd", DA, K_BZ, 1, 32'h0);
    chk("t5_bz11_nofwd", DB, K_BZ, 1, 32'h1);
    tick(); drive(0, 0, 0, 0, 0, 9, 11, 9);
    chk("t5_end_cnt_a", DA, K_CNT, 0, 32'h0);
    chk("t5_end_cnt_b", DB, K_CNT, 0, 32'h0);

    // Fill all then drain
    for (int i = 1; i < 32; i++) begin
      tick(); drive(0, 0, 0, 1, i[AW-1:0], i[AW-1:0], 1, 31);
      chk("t6_fill_cnt", DA, K_CNT, 0, 32'(i - 1));
      chk("t6_fill_bz1", DA, K_BZ, 1, (i > 1) ? 32'h1 : 32'h0);
    end
    tick(); drive(0, 0, 0, 0, 0, 1, 16, 31);
    chk("t6_full_cnt_a", DA, K_CNT, 0, 32'd31);
    chk("t6_full_cnt_b", DB, K_CNT, 0, 32'd31);
    chk("t6_full_bz1", DA, K_BZ, 0, 32'h1);
    chk("t6_full_bz16", DA, K_BZ, 1, 32'h1);
    chk("t6_full_bz31", DA, K_BZ, 2, 32'h1);
    for (int i = 1; i < 32; i++) begin
      tick(); drive(1, i[AW-1:0], 32'(i * 3), 0, 0, i[AW-1:0], 1, 31);
      chk("t6_drain_cnt", DA, K_CNT, 0, 32'(32 - i));
    end
    tick(); drive(0, 0, 0, 0, 0, 1, 16, 31);
    chk("t6_empty_cnt_a", DA, K_CNT, 0, 32'h0);
    chk("t6_empty_cnt_b", DB, K_CNT, 0, 32'h0);
    chk("t6_empty_bz16", DA, K_BZ, 1, 32'h0);
    chk("t6_rd16", DA, K_RD, 1, 32'd48);

    // Mixed traffic against the reference state
    for (int n = 0; n < 200; n++) begin
      tick();
      for (int k = 0; k < NR; k++) ra[k] = AW'($urandom_range(0, 9));
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)), $urandom(),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)), ra[0], ra[1], ra[2]);
      for (int k = 0; k < NR; k++) begin
        chk("rnd_rd_a", DA, K_RD, k, m_read(ra[k], 1'b1));
        chk("rnd_rd_b", DB, K_RD, k, m_read(ra[k], 1'b0));
        chk("rnd_bz_a", DA, K_BZ, k, m_bz(ra[k], 1'b1));
        chk("rnd_bz_b", DB, K_BZ, k, m_bz(ra[k], 1'b0));
      end
      chk("rnd_cnt_a", DA, K_CNT, 0, m_cnt());
      chk("rnd_cnt_b", DB, K_CNT, 0, m_cnt());
    end

    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #5;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
